ps2_scan_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It oversamples and filters the PS/2 clock/data lines and deframes 11-bit frames with start, parity and stop checks plus an inter-bit timeout. It folds E0 (extended) and F0 (break) prefixes into single key events and buffers those events in a ready/valid FIFO. It replaces the earlier receiver clocked directly by `ps2_clk` and sits between the board PS/2 pins and the keyboard-to-RAM command logic.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_event_fifo.sv | 78 +++++++
 rtl/ps2_scan_receiver.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    // Frame deframer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Scan-code prefixes folded into the following key event.
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // One buffered key event.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int EVENT_W = $bits(ps2_event_t);

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small first-word-fall-through FIFO for decoded key events. The head entry
// is presented directly from storage; outputs read as zero while empty.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = EVENT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_DEPTH);
    assign empty = (count_q == '0);

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Event storage; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver in the system clock domain: synchronise and filter
// the pins, deframe 11-bit frames, fold E0/F0 prefixes into key events and
// queue them for a ready/valid consumer.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       is_break,
    output logic       is_extended,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FLT_ONE  = FW'(1);
    // Counter reads k-1 in the k-th cycle after a sample, so matching T-2
    // registers frame_err exactly TIMEOUT_CYCLES cycles after that sample.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    // ------------------------------------------------------------------
    // Input conditioning: index 0 is ps2_clk, index 1 is ps2_data.
    // ------------------------------------------------------------------
    logic [1:0] line_raw;
    logic [1:0] line_filt;

    assign line_raw = {ps2_data, ps2_clk};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic [1:0]    sync_q;
        logic [FW-1:0] flt_cnt_q, flt_cnt_d;
        logic          filt_q, filt_d;

        // Accept a new level only after FILTER_LEN consecutive differing samples.
        always_comb begin
            filt_d    = filt_q;
            flt_cnt_d = '0;
            if (sync_q[1] != filt_q) begin
                if (flt_cnt_q == FLT_LAST) begin
                    filt_d = sync_q[1];
                end else begin
                    flt_cnt_d = flt_cnt_q + FLT_ONE;
                end
            end
        end

        // Two-flop synchroniser and filter state; idle-high lines reset to 1.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q    <= 2'b11;
                flt_cnt_q <= '0;
                filt_q    <= 1'b1;
            end else begin
                sync_q    <= {sync_q[0], line_raw[gi]};
                flt_cnt_q <= flt_cnt_d;
                filt_q    <= filt_d;
            end
        end

        assign line_filt[gi] = filt_q;
    end

    // ------------------------------------------------------------------
    // Sample event on the filtered clock falling edge.
    // ------------------------------------------------------------------
    logic clk_prev_q;
    logic sample_evt;
    logic sample_bit;

    // Previous filtered clock level for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= line_filt[0];
        end
    end

    assign sample_evt = clk_prev_q && !line_filt[0];
    assign sample_bit = line_filt[1];

    // ------------------------------------------------------------------
    // Frame deframer with inter-bit timeout.
    // ------------------------------------------------------------------
    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          byte_done_q;
    logic [7:0]    byte_q;
    logic          frame_err_q;

    // Deframe start/data/parity/stop; any error or stall returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                tmo_cnt_q <= '0;
                if (sample_evt && !sample_bit) begin
                    state_q   <= ST_DATA;
                    bit_cnt_q <= '0;
                end
            end else if (sample_evt) begin
                tmo_cnt_q <= '0;
                case (state_q)
                    ST_DATA: begin
                        shift_q   <= {sample_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= sample_bit;
                        state_q  <= ST_STOP;
                    end
                    default: begin
                        if (sample_bit && odd_parity_ok(shift_q, parity_q)) begin
                            byte_done_q <= 1'b1;
                            byte_q      <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (tmo_cnt_q == TMO_LAST) begin
                frame_err_q <= 1'b1;
                state_q     <= ST_IDLE;
                tmo_cnt_q   <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder and event queue.
    // ------------------------------------------------------------------
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       overflow_q, overflow_d;
    logic       push;
    ps2_event_t push_evt;
    ps2_event_t head_evt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    assign key_valid = !fifo_empty;
    assign pop       = key_valid && key_ready;

    // Fold E0/F0 into flags; any other byte becomes an event and clears them.
    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        push          = 1'b0;
        push_evt.ext  = ext_q;
        push_evt.brk  = brk_q;
        push_evt.code = byte_q;
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_done_q) begin
            if (byte_q == PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        overflow_d = push && fifo_full && !pop;
    end

    // Prefix flags and the overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .pop_data  (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign key_code    = head_evt.code;
    assign is_break    = head_evt.brk;
    assign is_extended = head_evt.ext;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver. A queue-based model of the event
// stream predicts key outputs, frame_err and overflow every cycle; literal
// expectations on the popped stream and pulse counts pin the model.
module tb_ps2_scan_receiver;

    localparam int FL    = 8;
    localparam int TMO   = 200;
    localparam int DEPTH = 4;
    localparam int H     = 30;   // PS/2 half period in clk cycles
    // Pin change to visible frame_err / event, in clk edges.
    localparam int LAT_ERR = 3 + FL;
    localparam int LAT_EVT = 4 + FL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_ready = 1'b1;
    logic [7:0] key_code;
    logic       is_break;
    logic       is_extended;
    logic       key_valid;
    logic       frame_err;
    logic       overflow;

    ps2_scan_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_code    (key_code),
        .is_break    (is_break),
        .is_extended (is_extended),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Model state: queued events {ext,brk,code}, prefix flags, pulse expectations.
    logic [9:0] mq[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovf = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ferr_seen = 0;
    int ovf_seen = 0;
    logic [9:0] dut_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    logic [9:0]  exp_head;
    logic [12:0] exp_vec;
    logic [12:0] act_vec;
    always @(negedge clk) begin
        exp_head = (mq.size() > 0) ? mq[0] : 10'h000;
        exp_vec  = {mq.size() > 0, exp_head, exp_ferr, exp_ovf};
        act_vec  = {key_valid, is_extended, is_break, key_code, frame_err, overflow};
        check("outputs", 32'(act_vec), 32'(exp_vec));
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        if (frame_err) ferr_seen++;
        if (overflow) ovf_seen++;
        if (key_valid && key_ready) begin
            dut_log.push_back({is_extended, is_break, key_code});
            $display("pop ext=%0d brk=%0d code=%h", is_extended, is_break, key_code);
        end
        if (mq.size() > 0 && key_ready && rst_n) void'(mq.pop_front());
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model reaction to a completed good byte.
    task automatic model_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
        else exp_ovf = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // Send one full frame; bad_par flips the parity bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        logic        par;
        par  = (~^b) ^ bad_par;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i <= 10; i++) begin
            ps2_data = bits[i];
            tick(H);
            ps2_clk = 1'b0;
            if (i == 10) begin
                tick(LAT_ERR);
                if (bad_par) begin
                    exp_ferr = 1'b1;
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end
                tick(LAT_EVT - LAT_ERR);
                if (!bad_par) begin
                    if (b == 8'hE0) m_ext = 1'b1;
                    else if (b == 8'hF0) m_brk = 1'b1;
                    else model_push(b);
                end
                tick(H - LAT_EVT);
            end else begin
                tick(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(H);
        $display("frame %h sent bad_par=%0d", b, bad_par);
    endtask

    // Start bit plus ndata data bits, then the clock stops high.
    task automatic send_partial(input logic [7:0] b, input int ndata, input bit expect_timeout);
        logic [10:0] bits;
        bits = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i <= ndata; i++) begin
            ps2_data = bits[i];
            tick(H);
            ps2_clk = 1'b0;
            if (i < ndata) begin
                tick(H);
                ps2_clk = 1'b1;
            end
        end
        if (expect_timeout) begin
            for (int c = 1; c <= 2 + FL + TMO; c++) begin
                tick(1);
                if (c == H) ps2_clk = 1'b1;
            end
            exp_ferr = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
            ps2_data = 1'b1;
            tick(H);
        end else begin
            tick(H);
            ps2_clk = 1'b1;
            ps2_data = 1'b1;
            tick(10);
        end
        $display("partial frame %h with %0d data bits sent", b, ndata);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        mq.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf = 1'b0;
        tick(3);
        check("reset_outputs", 32'({key_valid, is_extended, is_break, key_code, frame_err, overflow}), 32'h0);
        rst_n = 1'b1;
        tick(5);
    endtask

    logic [9:0] exp_log[10];

    initial begin
        exp_log[0] = 10'h01C; exp_log[1] = 10'h11C; exp_log[2] = 10'h375;
        exp_log[3] = 10'h01C; exp_log[4] = 10'h032; exp_log[5] = 10'h016;
        exp_log[6] = 10'h01E; exp_log[7] = 10'h026; exp_log[8] = 10'h025;
        exp_log[9] = 10'h01C;

        tick(4);
        check("reset_outputs", 32'({key_valid, is_extended, is_break, key_code, frame_err, overflow}), 32'h0);
        rst_n = 1'b1;
        tick(10);

        // Plain make code.
        send_frame(8'h1C, 1'b0);
        // Break, then extended break.
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        // Parity error clears a pending break prefix.
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0);
        // Stalled frame times out, next frame decodes.
        send_partial(8'h32, 5, 1'b1);
        send_frame(8'h32, 1'b0);

        // Fill the FIFO with the consumer stalled; fifth event overflows.
        key_ready = 1'b0;
        send_frame(8'h16, 1'b0);
        send_frame(8'h1E, 1'b0);
        send_frame(8'h26, 1'b0);
        send_frame(8'h25, 1'b0);
        send_frame(8'h2E, 1'b0);
        check("fifo_head_full", 32'({key_valid, key_code}), 32'h116);
        key_ready = 1'b1;
        tick(10);
        check("fifo_drained", 32'(key_valid), 32'h0);

        // Two-cycle clock glitch with data low must not start a frame.
        ps2_data = 1'b0;
        tick(H);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(TMO + 40);
        ps2_data = 1'b1;
        tick(H);

        // Reset mid-frame with a queued event and a pending E0 prefix.
        key_ready = 1'b0;
        send_frame(8'h1C, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_partial(8'h1C, 3, 1'b0);
        reset_pulse();
        key_ready = 1'b1;
        send_frame(8'h1C, 1'b0);
        tick(20);

        check("frame_err_pulses", 32'(ferr_seen), 32'd2);
        check("overflow_pulses", 32'(ovf_seen), 32'd1);
        check("event_count", 32'(dut_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < dut_log.size()) check("event_stream", 32'(dut_log[i]), 32'(exp_log[i]));
            else check("event_stream", 32'h3FF, 32'(exp_log[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
